result_bcd_display: RTL

//  Downstream stage of the ALU result selector. Captures the selected 16-bit result and its

---
 rtl/result_bcd_display.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/result_bcd_display.sv
// Captures a 16-bit result, converts it to five BCD digits with a 16-cycle shift-add-3 engine,
// and scans the last completed value onto a 5-digit active-low 7-segment display.
module result_bcd_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] result_in,
  input  logic        overflow_in,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic        ovf_flag,
  output logic [6:0]  seg,
  output logic [4:0]  an
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [15:0]       r_bin;
  logic [19:0]       r_scratch;
  logic              r_ovf_cap;
  logic [4:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [19:0]       r_bcd;
  logic              r_ovf_flag;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_idx;

  logic [19:0]       w_adj;
  logic [19:0]       w_next;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic [6:0]        w_seg;

  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_adj  = add3(r_scratch);
  assign w_next = {w_adj[18:0], r_bin[15]};

  // The result is committed on the edge entering DONE so that done and the new bcd
  // are both visible during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_ovf_cap  <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf_flag <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin     <= result_in;
            r_scratch <= '0;
            r_ovf_cap <= overflow_in;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_next;
          r_bin     <= {r_bin[14:0], 1'b0};
          r_cnt     <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            r_bcd      <= w_next;
            r_ovf_flag <= r_ovf_cap;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // A digit is blank when it and every more significant digit are zero; units never blank.
  always_comb begin
    w_digit = r_bcd[3:0];
    w_blank = 1'b0;
    case (r_idx)
      3'd0: begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
      end
      3'd1: begin
        w_digit = r_bcd[7:4];
        w_blank = (r_bcd[19:4] == 16'd0);
      end
      3'd2: begin
        w_digit = r_bcd[11:8];
        w_blank = (r_bcd[19:8] == 12'd0);
      end
      3'd3: begin
        w_digit = r_bcd[15:12];
        w_blank = (r_bcd[19:12] == 8'd0);
      end
      3'd4: begin
        w_digit = r_bcd[19:16];
        w_blank = (r_bcd[19:16] == 4'd0);
      end
      default: begin
        w_digit = 4'd0;
        w_blank = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_seg = 7'b1111111;
    if (r_ovf_flag)   w_seg = 7'b0111111;
    else if (w_blank) w_seg = 7'b1111111;
    else              w_seg = digit_seg(w_digit);
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign ovf_flag = r_ovf_flag;
  assign seg      = w_seg;
  assign an       = ~(5'b00001 << r_idx);

endmodule
